sha256_padder: RTL and testbench
================================

# sha256_padder

Message-framing stage directly upstream of the SHA-256 core. Accepts a byte-granular message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit bit-length. It buffers each 512-bit block and drives the core's `data`/`write_enable`/`first_block`/`last_block` inputs as 16 contiguous words, throttled by the core's `busy`.

## Interface
- No parameters. Block size (16 words) and length width (64 bits) are fixed by SHA-256.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in 32: message word, byte 0 in bits [31:24].
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: padder accepts the word when `in_valid & in_ready`.
- `in_last` in 1: final word of the message; qualified by `in_valid`.
- `in_bytes` in 2: valid bytes in the last word. 0 = 4, 1..3 = that many, left-justified. Ignored unless `in_last`.
- `core_busy` in 1: core `busy` output.
- `data` out 32: word to the core.
- `write_enable` out 1: `data` valid. High for exactly 16 consecutive cycles per block.
- `first_block` out 1: high only on word 0 of a message's first block.
- `last_block` out 1: high only on word 0 of a message's final block.

## Operation
- Buffer: 16x32 register array `buf`, write index `idx` (4 bit), bit-length counter `len` (64 bit, wraps mod 2^64).
- Accepted word: `len += 8*nbytes` (nbytes = 4, or `in_bytes` when last). Unused low bytes are masked to 0.
- Flags: `first_pend` (set at reset and message end), `final_blk`, `pend80` (0x80 still owed to the next block).
- States:
  - FILL: `in_ready=1`. Writes `buf[idx]` and increments `idx`.
    - Non-last word at idx 15 -> WAIT.
    - Last word with nbytes<4: inserts 0x80 at byte nbytes.
    - Last word with nbytes=4 at idx<15: 0x80 goes in the next word, written by PAD.
    - Last word with nbytes=4 at idx=15: sets `pend80` -> WAIT.
    - `final_blk` = 1 if the 0x80 byte lands in word index ≤13, else 0.
    - After a last word, goes -> PAD, or -> WAIT if the block is full.
  - PAD: `in_ready=0`. Writes one word per cycle at `buf[idx]`:
    - 0x80000000 if `pend80` (then clears `pend80`);
    - else `len[63:32]` at idx 14 if `final_blk`;
    - else `len[31:0]` at idx 15 if `final_blk`;
    - else 0.
    - After idx 15 -> WAIT.
  - WAIT: `in_ready=0`. Goes -> EMIT when `core_busy=0`.
  - EMIT: emits `buf[0..15]` over 16 cycles with `write_enable=1`.
    - `first_block = first_pend & (k==0)`; `last_block = final_blk & (k==0)`.
    - At k=15 -> GUARD and clears `first_pend`.
  - GUARD: one cycle, `core_busy` ignored. Core busy rises ≤1 cycle after its 16th word.
    - -> PAD if padding is still owed (`pend80`, or a message ended with `final_blk=0`). PAD sets `final_blk=1` for this block.
    - -> FILL with `first_pend=1`, `len=0` if the emitted block was final.
    - -> FILL otherwise.
- Empty messages are not supported; every message has ≥1 byte.

## Timing
- Reset: all outputs 0 except `in_ready`=1 on the first cycle after reset. State FILL, `idx=0`, `len=0`, `first_pend=1`, other flags 0. `buf` contents don't-care.
- Reset mid-EMIT: `write_enable` drops on the next edge and the partial block is abandoned. The core is reset by the same `reset`.
- Latency from the last word accepted at idx i to the first EMIT cycle: (15−i) PAD cycles + 1 WAIT cycle, when `core_busy=0`.
- Input stalls (`in_valid=0`) during FILL never create gaps in `write_enable`.
- `in_valid` with `in_ready=0` is held by the source; no word is lost.

## Structure
- Shared package `sha256_pkg`:
  - constants `SHA_WORDS=16`, `SHA_LEN_W=64`, `PAD_MARK=32'h80000000`;
  - state enum `pad_state_t` {FILL, PAD, WAIT, EMIT, GUARD}.
- Sub-module `sha256_blk_buf`: 16x32 register file with one write port and one read port, indexed.
- FSM, length counter and masking live in the top level.

## Test plan
- "abc": one word 0x61626300, `in_last=1`, `in_bytes=3`.
  - Words 0x61626380, 14×0, 0x00000018.
  - `first_block` and `last_block` both high on word 0.
- 56-byte message (14 full words):
  - Block 1 has word 14 = 0x80000000, word 15 = 0, `first_block` only.
  - Block 2 is all 0 except word 15 = 0x000001C0, `last_block` only.
- 64-byte message (16 words, last `in_bytes=0`):
  - Block 2 word 0 = 0x80000000, word 15 = 0x00000200.
  - `in_ready` stays 0 from the 16th word until block 2 is emitted.
- `core_busy` held high for 60 cycles while block 2 is ready:
  - No `write_enable` until `core_busy` falls.
  - Then exactly 16 contiguous cycles.
- Random `in_valid` gaps within a 20-word message: both blocks still emitted contiguously with correct padding and length 0x280.
- `reset` asserted at EMIT word 7: all outputs 0 next cycle. A following "abc" message produces the "abc" block with `first_block=1`.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 framing constants and the padder state encoding.
// Pure definitions; no logic, no latency, no flow control.
package sha256_pkg;

  localparam int SHA_WORDS = 16;
  localparam int SHA_LEN_W = 64;
  localparam logic [31:0] PAD_MARK = 32'h8000_0000;

  typedef enum logic [2:0] {
    FILL,
    PAD,
    WAIT,
    EMIT,
    GUARD
  } pad_state_t;

endpackage

// File: rtl/sha256_blk_buf.sv
// One-block staging store: 16x32 registers, one write port, one async read port.
// Write lands on the next edge; read is combinational; never stalls.
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_idx,
  output logic [31:0] rd_data
);

  logic [31:0] mem [SHA_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: frames byte-granular words into padded 512-bit blocks for the core.
// Emits 16 contiguous words per block once core_busy is low; in_ready drops while padding/emitting.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  input  logic        core_busy,
  output logic [31:0] data,
  output logic        write_enable,
  output logic        first_block,
  output logic        last_block
);

  pad_state_t           state, state_n;
  logic [3:0]           idx, idx_n;
  logic [SHA_LEN_W-1:0] len, len_n;
  logic                 first_pend, first_pend_n;
  logic                 final_blk, final_blk_n;
  logic                 pend80, pend80_n;
  logic                 pad_owed, pad_owed_n;

  logic        buf_we;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata;
  logic [2:0]  nbytes;
  logic [31:0] keep_mask;
  logic [31:0] mark_bits;

  sha256_blk_buf u_blk_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_idx  (idx),
    .wr_data (buf_wdata),
    .rd_idx  (idx),
    .rd_data (buf_rdata)
  );

  // Byte count of the incoming word, plus the keep mask and the 0x80 marker position.
  always_comb begin
    nbytes    = (in_last && in_bytes != 2'd0) ? {1'b0, in_bytes} : 3'd4;
    keep_mask = 32'hFFFF_FFFF;
    mark_bits = 32'h0;
    case (nbytes)
      3'd1: begin keep_mask = 32'hFF00_0000; mark_bits = 32'h0080_0000; end
      3'd2: begin keep_mask = 32'hFFFF_0000; mark_bits = 32'h0000_8000; end
      3'd3: begin keep_mask = 32'hFFFF_FF00; mark_bits = 32'h0000_0080; end
      default: begin keep_mask = 32'hFFFF_FFFF; mark_bits = 32'h0; end
    endcase
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    len_n        = len;
    first_pend_n = first_pend;
    final_blk_n  = final_blk;
    pend80_n     = pend80;
    pad_owed_n   = pad_owed;
    buf_we       = 1'b0;
    buf_wdata    = 32'h0;
    in_ready     = 1'b0;
    write_enable = 1'b0;
    data         = 32'h0;
    first_block  = 1'b0;
    last_block   = 1'b0;

    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we    = 1'b1;
          buf_wdata = (in_data & keep_mask) | (in_last ? mark_bits : 32'h0);
          idx_n     = idx + 4'd1;
          len_n     = len + {58'd0, nbytes, 3'd0};
          if (in_last) begin
            // A full last word pushes the marker into the following word slot.
            pend80_n    = (nbytes == 3'd4);
            final_blk_n = (nbytes == 3'd4) ? (idx <= 4'd12) : (idx <= 4'd13);
            pad_owed_n  = !final_blk_n;
            state_n     = (idx == 4'd15) ? WAIT : PAD;
          end else if (idx == 4'd15) begin
            state_n = WAIT;
          end
        end
      end

      PAD: begin
        buf_we = 1'b1;
        idx_n  = idx + 4'd1;
        if (pend80) begin
          buf_wdata = PAD_MARK;
          pend80_n  = 1'b0;
        end else if (final_blk && idx == 4'd14) begin
          buf_wdata = len[63:32];
        end else if (final_blk && idx == 4'd15) begin
          buf_wdata = len[31:0];
        end
        if (idx == 4'd15) state_n = WAIT;
      end

      WAIT: begin
        if (!core_busy) state_n = EMIT;
      end

      EMIT: begin
        write_enable = 1'b1;
        data         = buf_rdata;
        first_block  = first_pend && (idx == 4'd0);
        last_block   = final_blk && (idx == 4'd0);
        idx_n        = idx + 4'd1;
        if (idx == 4'd15) begin
          state_n      = GUARD;
          first_pend_n = 1'b0;
        end
      end

      GUARD: begin
        // Core busy may lag the 16th word by a cycle, so it is not sampled here.
        if (pend80 || pad_owed) begin
          state_n     = PAD;
          final_blk_n = 1'b1;
          pad_owed_n  = 1'b0;
        end else if (final_blk) begin
          state_n      = FILL;
          first_pend_n = 1'b1;
          len_n        = '0;
          final_blk_n  = 1'b0;
        end else begin
          state_n = FILL;
        end
      end

      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      idx        <= 4'd0;
      len        <= '0;
      first_pend <= 1'b1;
      final_blk  <= 1'b0;
      pend80     <= 1'b0;
      pad_owed   <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      len        <= len_n;
      first_pend <= first_pend_n;
      final_blk  <= final_blk_n;
      pend80     <= pend80_n;
      pad_owed   <= pad_owed_n;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: a byte-level padding model fills an expected-word queue,
// a negedge monitor pops and compares every emitted word and checks 16-word runs.
module tb_sha256_padder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [1:0]  in_bytes = 2'd0;
  logic        core_busy = 1'b0;
  logic [31:0] data;
  logic        write_enable;
  logic        first_block;
  logic        last_block;

  typedef struct packed {
    logic [31:0] dat;
    logic        first;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         run = 0;
  int         word_no = 0;

  sha256_padder dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_bytes     (in_bytes),
    .core_busy    (core_busy),
    .data         (data),
    .write_enable (write_enable),
    .first_block  (first_block),
    .last_block   (last_block)
  );

  always #5 clk = ~clk;

  // Scoreboard: every emitted word must match the head of the queue; blocks are 16-word runs.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      run = 0;
    end else if (write_enable) begin
      run++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL emit_unexpected: got data=%h first=%b last=%b, required no output", data, first_block, last_block);
      end else begin
        e = exp_q.pop_front();
        word_no++;
        if ({data, first_block, last_block} !== {e.dat, e.first, e.last}) begin
          n_fail++;
          $display("FAIL emit_word #%0d: got data=%h first=%b last=%b, required data=%h first=%b last=%b",
                   word_no, data, first_block, last_block, e.dat, e.first, e.last);
        end
      end
    end else if (run != 0) begin
      n_checks++;
      if (run != 16) begin
        n_fail++;
        $display("FAIL block_run: got %0d contiguous words, required 16", run);
      end
      run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_msg(input int n, input logic [7:0] seed);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'(seed + 8'(i * 7)) ^ 8'($urandom_range(255, 0)));
  endtask

  // Reference padding done byte-wise: msg, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic push_expected();
    logic [7:0]  p[$];
    logic [63:0] bits;
    exp_t        e;
    int          nw;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nw = p.size() / 4;
    for (int w = 0; w < nw; w++) begin
      e.dat   = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
      e.first = (w == 0);
      e.last  = (w == nw - 16);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_msg(input int gap_max);
    int          n;
    int          nw;
    int          cnt;
    logic [31:0] d;
    n  = msg.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      repeat (gap_max > 0 ? $urandom_range(gap_max, 0) : 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      for (int j = 0; j < 4; j++) d[31-8*j -: 8] = (4*w + j < n) ? msg[4*w+j] : 8'hA5;
      in_data  = d;
      in_valid = 1'b1;
      in_last  = (w == nw - 1);
      in_bytes = (w == nw - 1) ? 2'(n % 4) : 2'($urandom_range(3, 0));
      cnt = 0;
      while (!in_ready && cnt < 1000) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready=%b after 1000 cycles, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cnt = 0;
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while (!(exp_q.size() == 0 && in_ready && !write_enable) && cnt < 3000);
    n_checks++;
    if (exp_q.size() != 0 || !in_ready) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words still expected, in_ready=%b, required 0 and 1", name, exp_q.size(), in_ready);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, write_enable, data, first_block, last_block} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got in_ready=%b we=%b data=%h first=%b last=%b, required 1 0 00000000 0 0",
               in_ready, write_enable, data, first_block, last_block);
    end
  endtask

  task automatic test_abc();
    exp_t e;
    msg = '{8'h61, 8'h62, 8'h63};
    e = '{dat: 32'h6162_6380, first: 1'b1, last: 1'b1};
    exp_q.push_back(e);
    for (int i = 1; i < 15; i++) begin
      e = '{dat: 32'h0, first: 1'b0, last: 1'b0};
      exp_q.push_back(e);
    end
    e = '{dat: 32'h0000_0018, first: 1'b0, last: 1'b0};
    exp_q.push_back(e);
    send_msg(0);
    wait_drain("abc");
  endtask

  task automatic test_56();
    build_msg(56, 8'h10);
    push_expected();
    send_msg(0);
    wait_drain("len56");
  endtask

  task automatic test_64();
    int bad = 0;
    int cnt = 0;
    build_msg(64, 8'h20);
    push_expected();
    send_msg(0);
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() <= 15 || cnt > 500) break;
      if (in_ready) bad++;
      cnt++;
    end
    n_checks++;
    if (bad != 0 || cnt > 500) begin
      n_fail++;
      $display("FAIL len64_in_ready: got in_ready high on %0d cycles (waited %0d), required 0 until block 2", bad, cnt);
    end
    wait_drain("len64");
  endtask

  task automatic test_busy();
    int seen = 0;
    int cnt = 0;
    build_msg(60, 8'h30);
    push_expected();
    send_msg(0);
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while (exp_q.size() > 16 && cnt < 500);
    core_busy = 1'b1;
    repeat (60) begin
      @(negedge clk);
      #1;
      if (write_enable) seen++;
    end
    n_checks++;
    if (seen != 0 || exp_q.size() != 16) begin
      n_fail++;
      $display("FAIL busy_hold: got %0d write cycles and %0d words left, required 0 and 16", seen, exp_q.size());
    end
    core_busy = 1'b0;
    wait_drain("busy");
  endtask

  task automatic test_gaps();
    build_msg(80, 8'h40);
    push_expected();
    send_msg(3);
    wait_drain("gaps");
  endtask

  task automatic test_back_to_back();
    build_msg(5, 8'h50);
    push_expected();
    send_msg(1);
    build_msg(54, 8'h60);
    push_expected();
    send_msg(1);
    build_msg(7, 8'h70);
    push_expected();
    send_msg(0);
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid_emit();
    int cnt = 0;
    msg = '{8'h61, 8'h62, 8'h63};
    push_expected();
    send_msg(0);
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while (exp_q.size() > 8 && cnt < 500);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    n_checks++;
    if ({write_enable, data, first_block, last_block} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_emit: got we=%b data=%h first=%b last=%b, required 0 00000000 0 0",
               write_enable, data, first_block, last_block);
    end
    @(negedge clk);
    reset = 1'b0;
    msg = '{8'h61, 8'h62, 8'h63};
    push_expected();
    send_msg(0);
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_56();
    test_64();
    test_busy();
    test_gaps();
    test_back_to_back();
    test_reset_mid_emit();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
